// File: rtl/tsg_pkg.sv
// Shared constants for the test signal generator: sample modes, FSM states
// and the default LFSR polynomial/seed.
package tsg_pkg;

  localparam logic [1:0] MODE_RANDOM  = 2'd0;
  localparam logic [1:0] MODE_RAMP    = 2'd1;
  localparam logic [1:0] MODE_IMPULSE = 2'd2;
  localparam logic [1:0] MODE_SQUARE  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } tsg_state_e;

  localparam logic [31:0] TSG_DEFAULT_MASK = 32'h8020_0003;
  localparam logic [31:0] TSG_DEFAULT_SEED = 32'hACE1_2345;

endpackage

// File: rtl/tsg_lfsr.sv
// Galois LFSR: loads SEED on reset (0 replaced by 1), shifts once per adv_i.
// Only the low OUT_W bits are exported.
module tsg_lfsr
  import tsg_pkg::*;
#(
  parameter int             W     = 32,
  parameter int             OUT_W = 16,
  parameter logic [W-1:0]   MASK  = W'(TSG_DEFAULT_MASK),
  parameter logic [W-1:0]   SEED  = W'(TSG_DEFAULT_SEED)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             adv_i,
  output logic [OUT_W-1:0] state_o
);

  localparam logic [W-1:0] SEED_EFF = (SEED == '0) ? W'(1) : SEED;

  logic [W-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (adv_i) begin
      state_d = (state_q >> 1) ^ (state_q[0] ? MASK : '0);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= SEED_EFF;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q[OUT_W-1:0];

endmodule

// File: rtl/test_signal_generator.sv
// Burst stimulus source (random/ramp/impulse/square) on a valid/ready stream.
// Optional abort input enabled by defining TSG_ABORT_EN.
module test_signal_generator
  import tsg_pkg::*;
#(
  parameter int                WIDTH     = 16,
  parameter int                LFSR_W    = 32,
  parameter logic [LFSR_W-1:0] LFSR_MASK = LFSR_W'(TSG_DEFAULT_MASK),
  parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(TSG_DEFAULT_SEED),
  parameter int                CNT_W     = 16
) (
  input  logic             clk_samplying,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] num_samples,
  input  logic [WIDTH-1:0] step,
`ifdef TSG_ABORT_EN
  input  logic             abort,
`endif
  output logic [WIDTH-1:0] signal,
  output logic             signal_valid,
  input  logic             signal_ready,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] IMPULSE_MAX = {1'b0, {(WIDTH-1){1'b1}}};

  tsg_state_e       state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] step_q, step_d;
  logic [WIDTH-1:0] sig_q, sig_d;
  logic [WIDTH-1:0] lfsr_out;
  logic             xfer;
  logic             abort_req;

`ifdef TSG_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // A consumed sample advances the LFSR even when abort overrides the FSM.
  assign xfer = (state_q == ST_RUN) && signal_ready;

  tsg_lfsr #(
    .W     (LFSR_W),
    .OUT_W (WIDTH),
    .MASK  (LFSR_MASK),
    .SEED  (SEED)
  ) u_lfsr (
    .clk_i   (clk_samplying),
    .rst_i   (rst),
    .adv_i   (xfer),
    .state_o (lfsr_out)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    num_d   = num_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    sig_d   = sig_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (num_samples == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
            mode_d  = mode;
            num_d   = num_samples;
            step_d  = step;
            cnt_d   = '0;
            case (mode)
              MODE_IMPULSE: sig_d = IMPULSE_MAX;
              MODE_SQUARE:  sig_d = step;
              default:      sig_d = '0;
            endcase
          end
        end
      end
      ST_RUN: begin
        if (abort_req) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (xfer) begin
          cnt_d = cnt_q + CNT_W'(1);
          case (mode_q)
            MODE_RAMP:    sig_d = sig_q + step_q;
            MODE_IMPULSE: sig_d = '0;
            MODE_SQUARE:  sig_d = '0 - sig_q;
            default:      sig_d = sig_q;
          endcase
          if (cnt_q == num_q - CNT_W'(1)) begin
            state_d = ST_DONE;
            cnt_d   = '0;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_samplying or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= '0;
      num_q   <= '0;
      step_q  <= '0;
      cnt_q   <= '0;
      sig_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      num_q   <= num_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      sig_q   <= sig_d;
    end
  end

  // Random samples come straight from the LFSR; other modes use sig_q.
  assign signal       = (state_q == ST_RUN && mode_q == MODE_RANDOM) ? lfsr_out : sig_q;
  assign signal_valid = (state_q == ST_RUN);
  assign busy         = (state_q == ST_RUN);
  assign done         = (state_q == ST_DONE);

endmodule

// File: tb/tb_test_signal_generator.sv
// Self-checking bench for test_signal_generator: directed bursts plus
// randomized bursts against a behavioural sample model.
module tb_test_signal_generator;

  localparam logic [31:0] MASK_M = 32'h8020_0003;
  localparam logic [31:0] SEED_M = 32'hACE1_2345;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] num_samples = 16'd0;
  logic [15:0] step = 16'd0;
  logic        abort = 1'b0;
  logic [15:0] signal;
  logic        signal_valid;
  logic        signal_ready = 1'b0;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] lfsr_m = SEED_M;

  always #5 clk = ~clk;

  test_signal_generator dut (
    .clk_samplying (clk),
    .rst           (rst),
    .start         (start),
    .mode          (mode),
    .num_samples   (num_samples),
    .step          (step),
`ifdef TSG_ABORT_EN
    .abort         (abort),
`endif
    .signal        (signal),
    .signal_valid  (signal_valid),
    .signal_ready  (signal_ready),
    .busy          (busy),
    .done          (done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_advance();
    lfsr_m = (lfsr_m >> 1) ^ (lfsr_m[0] ? MASK_M : 32'h0);
  endfunction

  function automatic logic [15:0] exp_sample(input logic [1:0] m, input int k, input logic [15:0] st);
    logic [31:0] p;
    case (m)
      2'd0: return lfsr_m[15:0];
      2'd1: begin
        p = 32'(k) * 32'(st);
        return p[15:0];
      end
      2'd2: return (k == 0) ? 16'h7FFF : 16'h0000;
      default: begin
        p = (k % 2 == 0) ? 32'(st) : 32'h0 - 32'(st);
        return p[15:0];
      end
    endcase
  endfunction

  // stop_kind: 0 run to completion, 1 reset after stop_at transfers, 2 abort.
  task automatic run_burst(input logic [1:0] m, input int n, input logic [15:0] st,
                           input int rdy_mode, input int stop_kind, input int stop_at,
                           input bit inject_start);
    int k = 0;
    int cyc = 0;
    int budget;
    int done_seen = 0;
    bit stalled = 0;
    bit tog = 0;
    logic [15:0] held = '0;
    budget = 40 * n + 50;
    @(negedge clk);
    start = 1'b1; mode = m; num_samples = 16'(n); step = st;
    @(negedge clk);
    start = 1'b0;
    if (n == 0) begin
      for (int i = 0; i < 3; i++) begin
        check_eq("n0_valid", {31'b0, signal_valid}, 32'd0);
        check_eq("n0_busy", {31'b0, busy}, 32'd0);
        if (done) done_seen++;
        @(negedge clk);
      end
      check_eq("n0_done_pulses", 32'(done_seen), 32'd1);
      $display("burst mode=%0d n=0 step=%h transfers=0", m, st);
      return;
    end
    while (k < n && cyc < budget) begin
      check_eq("run_valid", {31'b0, signal_valid}, 32'd1);
      check_eq("run_busy", {31'b0, busy}, 32'd1);
      check_eq("run_done", {31'b0, done}, 32'd0);
      if (stalled) check_eq("stall_hold", {16'b0, signal}, {16'b0, held});
      check_eq("sample", {16'b0, signal}, {16'b0, exp_sample(m, k, st)});
      if (stop_kind == 1 && k == stop_at) begin
        rst = 1'b1;
        #1;
        check_eq("rst_valid", {31'b0, signal_valid}, 32'd0);
        check_eq("rst_signal", {16'b0, signal}, 32'd0);
        check_eq("rst_busy", {31'b0, busy}, 32'd0);
        check_eq("rst_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        signal_ready = 1'b0;
        lfsr_m = SEED_M;
        $display("burst mode=%0d n=%0d step=%h reset after %0d", m, n, st, k);
        return;
      end
      case (rdy_mode)
        0: signal_ready = 1'b1;
        1: begin signal_ready = tog; tog = ~tog; end
        default: signal_ready = 1'($urandom_range(0, 1));
      endcase
      start = (inject_start && k >= 1) ? 1'b1 : 1'b0;
      if (inject_start) mode = ~m;
      if (stop_kind == 2 && k == stop_at) begin
        abort = 1'b1;
        if (signal_ready) model_advance();
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        signal_ready = 1'b0;
        check_eq("abort_valid", {31'b0, signal_valid}, 32'd0);
        check_eq("abort_busy", {31'b0, busy}, 32'd0);
        check_eq("abort_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        check_eq("abort_done2", {31'b0, done}, 32'd0);
        $display("burst mode=%0d n=%0d step=%h aborted after %0d", m, n, st, k);
        return;
      end
      if (signal_ready) begin
        k++;
        model_advance();
        stalled = 0;
      end else begin
        stalled = 1;
        held = signal;
      end
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    signal_ready = 1'b0;
    if (k < n) check_eq("burst_timeout", 32'(k), 32'(n));
    check_eq("end_valid", {31'b0, signal_valid}, 32'd0);
    check_eq("end_busy", {31'b0, busy}, 32'd0);
    check_eq("end_done", {31'b0, done}, 32'd1);
    @(negedge clk);
    check_eq("end_done_clear", {31'b0, done}, 32'd0);
    check_eq("end_valid2", {31'b0, signal_valid}, 32'd0);
    $display("burst mode=%0d n=%0d step=%h transfers=%0d", m, n, st, k);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_eq("reset_valid", {31'b0, signal_valid}, 32'd0);
    check_eq("reset_busy", {31'b0, busy}, 32'd0);
    check_eq("reset_done", {31'b0, done}, 32'd0);
    check_eq("reset_signal", {16'b0, signal}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_burst(2'd0, 3, 16'h0000, 0, 0, 0, 1'b0);
    run_burst(2'd1, 4, 16'h7FFF, 0, 0, 0, 1'b0);
    run_burst(2'd2, 5, 16'h0000, 1, 0, 0, 1'b0);
    run_burst(2'd3, 4, 16'h0100, 0, 0, 0, 1'b1);
    run_burst(2'd0, 0, 16'h0000, 0, 0, 0, 1'b0);
    run_burst(2'd0, 10, 16'h0000, 0, 1, 2, 1'b0);
    run_burst(2'd0, 3, 16'h0000, 0, 0, 0, 1'b0);
`ifdef TSG_ABORT_EN
    run_burst(2'd0, 8, 16'h0000, 2, 2, 2, 1'b0);
    run_burst(2'd0, 3, 16'h0000, 0, 0, 0, 1'b0);
`endif
    for (int i = 0; i < 25; i++) begin
      run_burst(2'($urandom_range(0, 3)), int'($urandom_range(0, 12)),
                16'($urandom), 2, 0, 0, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
